sw_input_sequencer: RTL and testbench

SW_INPUT_SEQUENCER -- requirements
Module: sw_input_sequencer

---
 rtl/sw_seq_pkg.sv | 16 +
 rtl/sw_input_sequencer_if.sv | 27 ++
 rtl/sw_debounce.sv | 52 +++++
 rtl/sw_input_sequencer.sv | 119 +++++++++++
 tb/tb_sw_input_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_seq_pkg.sv
// Shared types and default parameters for the switch-driven operand sequencer.
package sw_seq_pkg;

  localparam int N_DEF          = 8;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int NUM_OPS_DEF    = 2;

  typedef enum logic [2:0] {
    ST_ARM          = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_HOLD         = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_WAIT_RESULT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sw_input_sequencer_if.sv
// Operand/result handshake between the switch sequencer (master) and the CPU core (slave).
interface sw_input_sequencer_if
  import sw_seq_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
);
  localparam int IDX_W = $clog2(NUM_OPS + 1);

  logic             op_valid;
  logic             op_ready;
  logic [n-1:0]     op_data;
  logic [IDX_W-1:0] op_index;
  logic             result_valid;
  logic [n-1:0]     result_data;

  modport master (
    output op_valid, op_data, op_index,
    input  op_ready, result_valid, result_data
  );

  modport slave (
    input  op_valid, op_data, op_index,
    output op_ready, result_valid, result_data
  );

endinterface

// File: rtl/sw_debounce.sv
// Synchronizes the operand-enter push switch and debounces it; emits one-cycle
// registered rise/fall pulses coincident with the debounced level change.
module sw_debounce
  import sw_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] sync_q;
  logic [7:0] cnt_q;
  logic       deb_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
      cnt_q  <= 8'd0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == deb_q) begin
        cnt_q <= 8'd0;
      end else if (cnt_q >= CNT_LAST) begin
        deb_q  <= sync_q[1];
        cnt_q  <= 8'd0;
        rise_q <= sync_q[1];
        fall_q <= ~sync_q[1];
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sw_input_sequencer.sv
// Collects NUM_OPS operands from switch presses, hands each to the CPU core over
// a valid/ready handshake, then waits for and displays the core's result.
module sw_input_sequencer
  import sw_seq_pkg::*;
#(
  parameter int n          = N_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int NUM_OPS    = NUM_OPS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw8,
  input  logic [n-1:0]         sws,
  output logic [n-1:0]         display,
  sw_input_sequencer_if.master bus
);

  localparam int               IDX_W    = $clog2(NUM_OPS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);
  // ARM must see the debounced level low long enough for a switch held through
  // reset to propagate through the synchronizer and debouncer first.
  localparam logic [8:0]       ARM_WAIT = 9'(DEB_CYCLES + 3);

  logic             deb_lvl;
  logic             deb_rise;
  logic             deb_fall;
  logic [n-1:0]     sws_meta_q;
  logic [n-1:0]     sws_sync_q;

  seq_state_e       state_q;
  logic [8:0]       arm_tmr_q;
  logic             op_valid_q;
  logic [n-1:0]     op_data_q;
  logic [IDX_W-1:0] op_index_q;
  logic [n-1:0]     display_q;

  sw_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .sw_i   (sw8),
    .deb_o  (deb_lvl),
    .rise_o (deb_rise),
    .fall_o (deb_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sws_meta_q <= '0;
      sws_sync_q <= '0;
    end else begin
      sws_meta_q <= sws;
      sws_sync_q <= sws_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARM;
      arm_tmr_q  <= ARM_WAIT;
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      op_index_q <= '0;
      display_q  <= '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (deb_lvl) begin
            arm_tmr_q <= ARM_WAIT;
          end else if (arm_tmr_q != 9'd0) begin
            arm_tmr_q <= arm_tmr_q - 9'd1;
          end else begin
            state_q <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (deb_rise) begin
            op_data_q  <= sws_sync_q;
            display_q  <= sws_sync_q;
            op_valid_q <= 1'b1;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (op_valid_q && bus.op_ready) begin
            op_valid_q <= 1'b0;
            op_index_q <= op_index_q + IDX_W'(1);
            state_q    <= (op_index_q == IDX_LAST) ? ST_WAIT_RESULT : ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          // The release may already have been debounced while the operand was held.
          if (deb_fall || !deb_lvl) begin
            state_q <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_RESULT: begin
          if (bus.result_valid) begin
            display_q  <= bus.result_data;
            op_index_q <= '0;
            arm_tmr_q  <= ARM_WAIT;
            state_q    <= ST_ARM;
          end
        end
        default: begin
          arm_tmr_q <= ARM_WAIT;
          state_q   <= ST_ARM;
        end
      endcase
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_data  = op_data_q;
  assign bus.op_index = op_index_q;
  assign display      = display_q;

endmodule

// File: tb/tb_sw_input_sequencer.sv
// Directed bench: stimulus pushes expected operands into a queue, a forked monitor
// checks every handshake transfer against it; level checks are made inline.
module tb_sw_input_sequencer;
  import sw_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       sw8;
  logic [7:0] sws;
  logic [7:0] display;

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_q[$];

  sw_input_sequencer_if #(.n(8), .NUM_OPS(2)) bus ();

  sw_input_sequencer #(
    .n          (8),
    .DEB_CYCLES (4),
    .NUM_OPS    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw8     (sw8),
    .sws     (sws),
    .display (display),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      seen = bus.op_valid;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: op_valid got 0 after 40 cycles, expected 1", name);
    end
  endtask

  task automatic monitor();
    logic       prev_valid = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.op_valid && !prev_valid) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_op_valid: got op_valid=1 data=%0h, expected no operand", bus.op_data);
          end
        end
        if (bus.op_valid && bus.op_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_transfer: got transfer data=%0h, expected none", bus.op_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.op_data, bus.op_index} !== e) begin
              fails++;
              $display("FAIL transfer: got data=%0h idx=%0d, expected data=%0h idx=%0d",
                       bus.op_data, bus.op_index, e[9:2], e[1:0]);
            end
          end
        end
      end
      prev_valid = bus.op_valid;
    end
  endtask

  initial begin
    int first_k;

    reset            = 1'b0;
    sw8              = 1'b1;
    sws              = 8'h00;
    bus.op_ready     = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_data  = 8'h00;
    fork
      monitor();
    join_none

    #1;
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_op_data", 32'(bus.op_data), 32'd0);
    check("rst_op_index", 32'(bus.op_index), 32'd0);
    check("rst_display", 32'(display), 32'd0);

    // Switch held through reset and afterwards must never capture.
    step(2);
    reset = 1'b1;
    step(100);
    check("held_state_arm", 32'(dut.state_q), 32'(ST_ARM));
    check("held_no_valid", 32'(bus.op_valid), 32'd0);

    sw8 = 1'b0;
    step(25);
    check("armed_wait_press", 32'(dut.state_q), 32'(ST_WAIT_PRESS));

    bus.result_valid = 1'b1;
    bus.result_data  = 8'hFF;
    step(1);
    bus.result_valid = 1'b0;
    step(1);
    check("stray_result_display", 32'(display), 32'd0);

    bus.op_ready = 1'b1;
    step(3);
    bus.op_ready = 1'b0;
    check("stray_ready_index", 32'(bus.op_index), 32'd0);

    for (int g = 1; g <= 3; g++) begin
      sws = 8'(8'h10 * g);
      sw8 = 1'b1;
      step(g);
      sw8 = 1'b0;
      step(12);
      check($sformatf("glitch%0d_state", g), 32'(dut.state_q), 32'(ST_WAIT_PRESS));
      check($sformatf("glitch%0d_display", g), 32'(display), 32'd0);
    end

    // First operand with press-to-valid latency measurement.
    bus.op_ready = 1'b1;
    exp_q.push_back({8'h08, 2'd0});
    sws = 8'h08;
    sw8 = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (bus.op_valid && first_k == 0) first_k = k;
    end
    check("press_latency", 32'(first_k), 32'd7);
    check("op1_index", 32'(bus.op_index), 32'd1);
    check("op1_valid_drop", 32'(bus.op_valid), 32'd0);
    check("op1_echo", 32'(display), 32'h08);

    sw8 = 1'b0;
    step(12);
    exp_q.push_back({8'h04, 2'd1});
    sws = 8'h04;
    sw8 = 1'b1;
    wait_valid("op2_valid");
    step(2);
    check("op2_index", 32'(bus.op_index), 32'd2);
    check("op2_state", 32'(dut.state_q), 32'(ST_WAIT_RESULT));
    check("op2_echo", 32'(display), 32'h04);
    sw8 = 1'b0;
    step(10);

    bus.result_valid = 1'b1;
    bus.result_data  = 8'h0C;
    step(1);
    bus.result_valid = 1'b0;
    bus.result_data  = 8'h00;
    check("result_display", 32'(display), 32'h0C);
    check("result_index", 32'(bus.op_index), 32'd0);
    check("result_state", 32'(dut.state_q), 32'(ST_ARM));

    // Backpressure: operand held while the switch is released and pressed again.
    step(20);
    bus.op_ready = 1'b0;
    exp_q.push_back({8'hA5, 2'd0});
    sws = 8'hA5;
    sw8 = 1'b1;
    wait_valid("hold_valid");
    begin
      bit stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (i == 2) sw8 = 1'b0;
        if (i == 8) begin
          sw8 = 1'b1;
          sws = 8'h5A;
        end
        if (i == 14) sw8 = 1'b0;
        step(1);
        if (!(bus.op_valid === 1'b1 && bus.op_data === 8'hA5)) stable = 1'b0;
      end
      check("hold_stable", 32'(stable), 32'd1);
    end
    check("hold_no_echo", 32'(display), 32'hA5);
    bus.op_ready = 1'b1;
    step(10);
    bus.op_ready = 1'b0;
    check("hold_one_transfer_index", 32'(bus.op_index), 32'd1);
    check("hold_valid_drop", 32'(bus.op_valid), 32'd0);
    step(5);

    // Reset in HOLD with one operand already transferred.
    exp_q.push_back({8'h33, 2'd1});
    sws = 8'h33;
    sw8 = 1'b1;
    wait_valid("midrst_valid");
    step(2);
    check("midrst_pre_index", 32'(bus.op_index), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_op_valid", 32'(bus.op_valid), 32'd0);
    check("midrst_op_data", 32'(bus.op_data), 32'd0);
    check("midrst_op_index", 32'(bus.op_index), 32'd0);
    check("midrst_display", 32'(display), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_ARM));
    exp_q.delete();
    step(1);
    reset = 1'b1;
    step(30);
    check("postrst_held_valid", 32'(bus.op_valid), 32'd0);
    check("postrst_held_state", 32'(dut.state_q), 32'(ST_ARM));

    sw8 = 1'b0;
    step(25);
    bus.op_ready = 1'b1;
    exp_q.push_back({8'h77, 2'd0});
    sws = 8'h77;
    sw8 = 1'b1;
    wait_valid("fresh_valid");
    step(3);
    check("fresh_index", 32'(bus.op_index), 32'd1);
    check("fresh_echo", 32'(display), 32'h77);
    sw8 = 1'b0;
    step(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
